// File: rtl/cpa_pkg.sv
// cpa_pkg -- shared constants for the carry-propagate pipeline.
//   Default widths of the compressor outputs feeding cpa_pipe, the result
//   width and the low-segment split point, plus a helper that sizes the
//   upper segment adder.  Configuration macro used by the users of this
//   package: CPA_COUT_EN (adds bit W_OUT of the sum as a carry-out).
package cpa_pkg;

  localparam int W_A     = 14;  // wide redundant vector (weight 2^0)
  localparam int W_B     = 10;  // narrow redundant vector (weight 2^B_SHIFT)
  localparam int B_SHIFT = 3;
  localparam int W_OUT   = 14;  // result width, modulo 2^W_OUT
  localparam int SEG     = 7;   // bits resolved in stage 1
  localparam int W_HI    = W_OUT - SEG;

  // Width of the stage-2 adder: the upper result bits, plus one extra bit
  // when the carry-out (bit W_OUT of the full sum) is produced.
  function automatic int hi_width(input int w_out, input int seg, input bit cout_en);
    return w_out - seg + (cout_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/cpa_seg.sv
// cpa_seg -- combinational N-bit adder segment with carry in and carry out.
//   a, b  : N-bit addends
//   cin   : carry into bit 0
//   sum   : N-bit sum
//   cout  : carry out of bit N-1
module cpa_seg #(
  parameter int N = 7
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] full;

  assign full = (N+1)'(a) + (N+1)'(b) + (N+1)'(cin);
  assign sum  = full[N-1:0];
  assign cout = full[N];

endmodule

// File: rtl/cpa_pipe.sv
// cpa_pipe -- final carry-propagate adder of the multiplier datapath.
//   Adds the compressor's redundant vectors: in_a at weight 2^0 and in_b at
//   weight 2^B_SHIFT, giving out_sum = (in_a + (in_b << B_SHIFT)) mod 2^W_OUT.
//   Two pipeline stages: stage 1 resolves the low SEG bits and its carry,
//   stage 2 resolves the upper bits.  Valid/ready handshakes on both sides,
//   full throughput, back-pressure ripples back one stage per cycle.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   in_a [W_A], in_b [W_B]  redundant operand vectors
//   out_valid/out_ready output handshake
//   out_sum [W_OUT]     result
//   out_cout            bit W_OUT of the full sum; present only when the
//                       CPA_COUT_EN macro is defined
module cpa_pipe #(
  parameter int W_A     = cpa_pkg::W_A,
  parameter int W_B     = cpa_pkg::W_B,
  parameter int B_SHIFT = cpa_pkg::B_SHIFT,
  parameter int W_OUT   = cpa_pkg::W_OUT,
  parameter int SEG     = cpa_pkg::SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_A-1:0]   in_a,
  input  logic [W_B-1:0]   in_b,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef CPA_COUT_EN
  output logic             out_cout,
`endif
  output logic [W_OUT-1:0] out_sum
);

  import cpa_pkg::*;

`ifdef CPA_COUT_EN
  localparam bit COUT_EN = 1'b1;
`else
  localparam bit COUT_EN = 1'b0;
`endif

  // Operand width seen by the adders and width of the upper segment.
  localparam int W_X  = W_OUT + (COUT_EN ? 1 : 0);
  localparam int W_U  = hi_width(W_OUT, SEG, COUT_EN);
  localparam int W_UP = W_OUT - SEG;

  // ---------------------------------------------------------------- control
  logic s1_valid_reg;
  logic out_valid_reg;
  logic s1_en;
  logic s2_en;

  assign s2_en    = !out_valid_reg || out_ready;
  assign s1_en    = !s1_valid_reg || s2_en;
  assign in_ready = s1_en;
  assign out_valid = out_valid_reg;

  // ---------------------------------------------------------------- stage 1
  // Operands aligned to their weights; anything at or above bit W_X cannot
  // affect the kept result and is truncated here.
  logic [W_X-1:0] a_ext;
  logic [W_X-1:0] b_ext;

  assign a_ext = W_X'(in_a);
  assign b_ext = W_X'(in_b) << B_SHIFT;

  logic [SEG-1:0] lo_sum;
  logic           lo_carry;

  cpa_seg #(.N(SEG)) u_seg_lo (
    .a    (a_ext[SEG-1:0]),
    .b    (b_ext[SEG-1:0]),
    .cin  (1'b0),
    .sum  (lo_sum),
    .cout (lo_carry)
  );

  logic [SEG-1:0] s1_lo_reg;
  logic           s1_c1_reg;
  logic [W_U-1:0] s1_a_hi_reg;
  logic [W_U-1:0] s1_b_hi_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_lo_reg    <= '0;
      s1_c1_reg    <= 1'b0;
      s1_a_hi_reg  <= '0;
      s1_b_hi_reg  <= '0;
    end else if (s1_en) begin
      s1_valid_reg <= in_valid;
      // Data only moves on an accepted operand; otherwise it is don't-care
      // behind s1_valid_reg and keeping it avoids toggling on idle cycles.
      if (in_valid) begin
        s1_lo_reg   <= lo_sum;
        s1_c1_reg   <= lo_carry;
        s1_a_hi_reg <= a_ext[W_X-1:SEG];
        s1_b_hi_reg <= b_ext[W_X-1:SEG];
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [W_U-1:0] hi_sum;
  logic           hi_carry_unused;  // carry past the result is always dropped

  cpa_seg #(.N(W_U)) u_seg_hi (
    .a    (s1_a_hi_reg),
    .b    (s1_b_hi_reg),
    .cin  (s1_c1_reg),
    .sum  (hi_sum),
    .cout (hi_carry_unused)
  );

  logic [W_OUT-1:0] out_sum_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_sum_reg   <= '0;
    end else if (s2_en) begin
      // Reloading in the same cycle the consumer takes the old word gives
      // full throughput with no bubble.
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_sum_reg <= {hi_sum[W_UP-1:0], s1_lo_reg};
      end
    end
  end

  assign out_sum = out_sum_reg;

`ifdef CPA_COUT_EN
  logic out_cout_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cout_reg <= 1'b0;
    end else if (s2_en && s1_valid_reg) begin
      out_cout_reg <= hi_sum[W_U-1];
    end
  end

  assign out_cout = out_cout_reg;
`endif

endmodule

// File: tb/tb_cpa_pipe.sv
// tb_cpa_pipe -- self-checking bench for cpa_pipe.
//   Directed steps (reset, carry across the segment boundary, overflow,
//   back-to-back stream, stall/back-pressure, reset mid-stream) followed by
//   randomized traffic, all checked against an arithmetic reference model
//   held in a queue of expected results.  Build with +define+CPA_COUT_EN to
//   also check the carry-out port.
module tb_cpa_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] in_a;
  logic [9:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] out_sum;
`ifdef CPA_COUT_EN
  logic        out_cout;
`endif

  cpa_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef CPA_COUT_EN
    .out_cout  (out_cout),
`endif
    .out_sum   (out_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_in  = 0;
  int n_out = 0;
  bit last_acc_in;
  bit stall_prev;
  logic [13:0] held_sum;

  // Expected results in acceptance order: {cout, sum}.
  logic [14:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference: plain integer arithmetic on the whole sum.
  function automatic logic [14:0] model(input logic [13:0] a, input logic [9:0] b);
    int unsigned full;
    full = int'(a) + (int'(b) * 8);
    return {1'(full >> 14), 14'(full % 16384)};
  endfunction

  // One clock cycle: drive inputs after the falling edge, sample the
  // handshakes just before the rising edge, end on the next falling edge.
  task automatic step(input logic v, input logic [13:0] a, input logic [9:0] b, input logic r);
    logic [14:0] e;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    out_ready = r;
    #1;
    if (stall_prev) chk("stall_hold", 32'(out_sum), 32'(held_sum));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sum", 32'(out_sum), 32'(e[13:0]));
`ifdef CPA_COUT_EN
        chk("cout", 32'(out_cout), 32'(e[14]));
`endif
        $display("[TB] out #%0d sum=%h", n_out, out_sum);
        n_out++;
      end
    end
    last_acc_in = in_valid && in_ready;
    if (last_acc_in) begin
      exp_q.push_back(model(a, b));
      n_in++;
    end
    stall_prev = out_valid && !out_ready;
    held_sum   = out_sum;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      step(1'b0, 14'h0, 10'h0, 1'b1);
      guard++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [13:0] sa[3];
    logic [9:0]  sb[3];
    int idx;
    int cyc;
    int base_out;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    stall_prev = 1'b0; held_sum = '0; last_acc_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
`ifdef CPA_COUT_EN
    chk("rst_out_cout", 32'(out_cout), 32'd0);
`endif
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Carry out of the low segment into the upper one; two-cycle latency.
    step(1'b1, 14'h0078, 10'h001, 1'b1);
    chk("lat1_out_valid", 32'(out_valid), 32'd0);
    step(1'b0, 14'h0, 10'h0, 1'b1);
    chk("lat2_out_valid", 32'(out_valid), 32'd1);
    chk("lat2_out_sum", 32'(out_sum), 32'h0080);
    drain();

    // Overflow past the result width wraps; carry-out reports bit 14.
    step(1'b1, 14'h3FFF, 10'h001, 1'b1);
    step(1'b0, 14'h0, 10'h0, 1'b1);
    chk("ovf_out_sum", 32'(out_sum), 32'h0007);
`ifdef CPA_COUT_EN
    chk("ovf_out_cout", 32'(out_cout), 32'd1);
`endif
    drain();

    // Back-to-back stream A=B=i: one result per cycle, never back-pressured.
    base_out = n_out;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 14'(i), 10'(i), 1'b1);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
    end
    chk("stream_results", 32'(n_out - base_out), 32'd98);
    drain();

    // Back-pressure: three operands offered while the consumer stalls.
    sa[0] = 14'h0123; sb[0] = 10'h3FF;
    sa[1] = 14'h3F00; sb[1] = 10'h055;
    sa[2] = 14'h1ABC; sb[2] = 10'h2AA;
    idx = 0;
    base_out = n_in;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, sa[idx], sb[idx], 1'b0);
      if (last_acc_in) idx++;
    end
    chk("stall_accepted", 32'(n_in - base_out), 32'd2);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    cyc = 0;
    while (idx < 3 && cyc < 10) begin
      step(1'b1, sa[idx], sb[idx], 1'b1);
      if (last_acc_in) idx++;
      cyc++;
    end
    chk("release_accept", 32'(idx), 32'd3);
    drain();

    // Reset with both stages full: outputs clear immediately.
    step(1'b1, 14'h1111, 10'h222, 1'b0);
    step(1'b1, 14'h2222, 10'h111, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_sum", 32'(out_sum), 32'd0);
    exp_q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 14'h0005, 10'h002, 1'b1);
    chk("postrst_lat1", 32'(out_valid), 32'd0);
    step(1'b0, 14'h0, 10'h0, 1'b1);
    chk("postrst_lat2", 32'(out_valid), 32'd1);
    chk("postrst_sum", 32'(out_sum), 32'h0015);
    drain();

    // Random operands and random flow control on both sides.
    base_out = n_in;
    cyc = 0;
    while ((n_in - base_out) < 10000 && cyc < 60000) begin
      step(1'($urandom_range(0, 9) < 7), 14'($urandom), 10'($urandom),
           1'($urandom_range(0, 9) < 7));
      cyc++;
    end
    chk("random_complete", 32'(n_in - base_out), 32'd10000);
    drain();
    chk("all_results", 32'(n_out), 32'(n_in - 2));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
